// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the ALU arbiter.
//  - ALU select encodings (ADD=0 .. AND=9, SELA=14, SELB=15)
//  - is_illegal_sel(): flags the reserved select range 4'b1010..4'b1101
//  - arbiter FSM state enum
package alu_arb_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9,
        AluSelA = 4'd14,
        AluSelB = 4'd15
    } alu_sel_e;

    localparam logic [3:0] ILLEGAL_SEL_LO = 4'd10;
    localparam logic [3:0] ILLEGAL_SEL_HI = 4'd13;

    typedef enum logic {
        StIdle,
        StResp
    } state_e;

    function automatic logic is_illegal_sel(input logic [3:0] sel);
        return (sel >= ILLEGAL_SEL_LO) && (sel <= ILLEGAL_SEL_HI);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//  Scans the request vector circularly starting at ptr and returns the first
//  set bit as a one-hot grant plus its encoded index.
// Ports:
//  req          in   NUM_REQ  request vector
//  ptr          in   ID_W     highest-priority position this cycle
//  grant        out  NUM_REQ  one-hot grant, zero when no request
//  grant_idx    out  ID_W     encoded grant (0 when no request)
//  grant_valid  out  1        any request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int unsigned idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Modulo handles NUM_REQ that are not a power of two.
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = ID_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle integer ALU between NUM_REQ requesters.
//  Round-robin grant, one operation in flight, registered result on a shared
//  response port tagged with the requester ID. Back-to-back operation gives one
//  result per cycle while rsp_ready stays high.
// Ports:
//  clk, rst_n                  clock (rising edge), async active-low reset
//  req_valid / req_ready       per-requester handshake, req_ready one-hot or zero
//  req_data_a / req_data_b     packed operands, requester i at slice i
//  req_alusel                  packed ALU selects
//  alu_data_a/_b, alu_sel      to the ALU
//  alu_data_out                combinational ALU result
//  rsp_valid / rsp_ready       response handshake
//  rsp_data, rsp_id, rsp_err   registered result, owner ID, illegal-select flag
// Build option:
//  ALU_ARB_PERF_EN  adds perf_ops[31:0] (accepted requests) and
//                   perf_stall[31:0] (cycles with rsp_valid & !rsp_ready),
//                   both saturating.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH_DATA_LENGTH   = 32,
    parameter int unsigned WIDTH_ALUSEL_LENGTH = 4,
    parameter int unsigned NUM_REQ             = 4,
    parameter int unsigned ID_W                = $clog2(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*WIDTH_DATA_LENGTH-1:0]   req_data_a,
    input  logic [NUM_REQ*WIDTH_DATA_LENGTH-1:0]   req_data_b,
    input  logic [NUM_REQ*WIDTH_ALUSEL_LENGTH-1:0] req_alusel,
    output logic [WIDTH_DATA_LENGTH-1:0]           alu_data_a,
    output logic [WIDTH_DATA_LENGTH-1:0]           alu_data_b,
    output logic [WIDTH_ALUSEL_LENGTH-1:0]         alu_sel,
    input  logic [WIDTH_DATA_LENGTH-1:0]           alu_data_out,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [WIDTH_DATA_LENGTH-1:0]           rsp_data,
    output logic [ID_W-1:0]                        rsp_id,
    output logic                                   rsp_err
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]                            perf_ops,
    output logic [31:0]                            perf_stall
`endif
);

    localparam int unsigned DW = WIDTH_DATA_LENGTH;
    localparam int unsigned SW = WIDTH_ALUSEL_LENGTH;

    state_e                  state_q;
    logic [ID_W-1:0]         rr_ptr_q;
    logic                    rsp_valid_q;
    logic [DW-1:0]           rsp_data_q;
    logic [ID_W-1:0]         rsp_id_q;
    logic                    rsp_err_q;
    // Copy of the operands last sent to the ALU, replayed while stalled so the
    // ALU inputs stay put even if the accepted requester has moved on.
    logic [DW-1:0]           hold_a_q;
    logic [DW-1:0]           hold_b_q;
    logic [SW-1:0]           hold_sel_q;

    logic [DW-1:0]           slice_a   [NUM_REQ];
    logic [DW-1:0]           slice_b   [NUM_REQ];
    logic [SW-1:0]           slice_sel [NUM_REQ];

    logic [NUM_REQ-1:0]      grant;
    logic [ID_W-1:0]         grant_idx;
    logic                    grant_valid;
    logic                    can_accept;
    logic                    grant_fire;
    logic                    stalled;
    logic                    sel_illegal;
    logic [ID_W-1:0]         rr_ptr_next;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign slice_a[i]   = req_data_a[i*DW +: DW];
        assign slice_b[i]   = req_data_b[i*DW +: DW];
        assign slice_sel[i] = req_alusel[i*SW +: SW];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // rst_n gates acceptance so nothing handshakes while reset is held.
    assign can_accept = rst_n && ((state_q == StIdle) || rsp_ready);
    assign grant_fire = can_accept && grant_valid;
    assign stalled    = (state_q == StResp) && !rsp_ready;
    assign req_ready  = grant_fire ? grant : '0;

    always_comb begin
        alu_data_a = slice_a[rr_ptr_q];
        alu_data_b = slice_b[rr_ptr_q];
        alu_sel    = slice_sel[rr_ptr_q];
        if (grant_fire) begin
            alu_data_a = slice_a[grant_idx];
            alu_data_b = slice_b[grant_idx];
            alu_sel    = slice_sel[grant_idx];
        end else if (stalled) begin
            alu_data_a = hold_a_q;
            alu_data_b = hold_b_q;
            alu_sel    = hold_sel_q;
        end
    end

    assign sel_illegal = is_illegal_sel(4'(alu_sel));
    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stall_q;
    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            hold_sel_q  <= '0;
`ifdef ALU_ARB_PERF_EN
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
`endif
        end else begin
            if (grant_fire) begin
                state_q     <= StResp;
                rsp_valid_q <= 1'b1;
                // The ALU output is meaningless for reserved selects.
                rsp_data_q  <= sel_illegal ? '0 : alu_data_out;
                rsp_id_q    <= grant_idx;
                rsp_err_q   <= sel_illegal;
                rr_ptr_q    <= rr_ptr_next;
                hold_a_q    <= alu_data_a;
                hold_b_q    <= alu_data_b;
                hold_sel_q  <= alu_sel;
            end else if ((state_q == StResp) && rsp_ready) begin
                state_q     <= StIdle;
                rsp_valid_q <= 1'b0;
            end
`ifdef ALU_ARB_PERF_EN
            if (grant_fire && (perf_ops_q != '1)) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (rsp_valid_q && !rsp_ready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

endmodule
